// File: rtl/odd_sequence_checker_if.sv
// Bus bundle for odd_sequence_checker: sample inputs and status outputs.
// The master drives Clear/Valid/D; the slave (the checker) drives status.
interface odd_sequence_checker_if #(
    parameter int N = 4
);
    logic         Clear;
    logic         Valid;
    logic [N-1:0] D;
    logic         Lock;
    logic         DirUp;
    logic         Error;
    logic         Fault;
    logic [7:0]   ErrCount;
    logic [15:0]  StepCount;

    modport master (
        output Clear, Valid, D,
        input  Lock, DirUp, Error, Fault, ErrCount, StepCount
    );

    modport slave (
        input  Clear, Valid, D,
        output Lock, DirUp, Error, Fault, ErrCount, StepCount
    );
endinterface

// File: rtl/odd_sequence_checker.sv
// odd_sequence_checker: tracks an odd-valued up/down counter (steps of +/-2
// modulo 2^N) and flags any sample that breaks the sequence.
// Optional statistics counters (ErrCount, StepCount) are built only when the
// macro ODD_CHECK_STATS_EN is defined; otherwise both outputs read 0.
//
// state | meaning
// IDLE  | no reference value yet; first odd sample becomes the reference
// TRACK | reference held in last_q; checking each sample against it
// FAULT | ERR_LIMIT consecutive rejects seen; left only by Clear or reset
module odd_sequence_checker #(
    parameter int N         = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic                  Clk,
    input  logic                  nReset,
    odd_sequence_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [N-1:0] STEP_UP  = N'(2);
    localparam logic [N-1:0] STEP_DN  = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] LAST_RST = N'(1);
    localparam logic [3:0]   LIMIT    = 4'(ERR_LIMIT);

    state_t       state_q, state_d;
    logic [N-1:0] last_q, last_d;
    logic         lock_q, lock_d;
    logic         dir_up_q, dir_up_d;
    logic         error_q, error_d;
    logic         fault_q, fault_d;
    logic [3:0]   consec_q, consec_d;

    logic [N-1:0] delta;
    logic         d_odd;
    logic         is_hold;
    logic         is_up;
    logic         is_dn;
    logic [3:0]   consec_inc;
    logic         reject;
    logic         step_ok;

    // Classify the incoming sample relative to the stored reference.
    always_comb begin
        delta      = bus.D - last_q;
        d_odd      = bus.D[0];
        is_hold    = d_odd && (delta == '0);
        is_up      = d_odd && (delta == STEP_UP);
        is_dn      = d_odd && (delta == STEP_DN);
        consec_inc = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
    end

    // Next-state and registered-output computation; Clear wins over Valid.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        lock_d   = lock_q;
        dir_up_d = dir_up_q;
        consec_d = consec_q;
        error_d  = 1'b0;
        reject   = 1'b0;
        step_ok  = 1'b0;

        if (bus.Clear) begin
            state_d  = IDLE;
            last_d   = LAST_RST;
            lock_d   = 1'b0;
            dir_up_d = 1'b1;
            consec_d = '0;
        end else if (bus.Valid) begin
            unique case (state_q)
                IDLE: begin
                    if (d_odd) begin
                        last_d  = bus.D;
                        lock_d  = 1'b0;
                        state_d = TRACK;
                    end else begin
                        reject = 1'b1;
                    end
                end
                TRACK: begin
                    if (is_hold) begin
                        consec_d = '0;
                    end else if (is_up) begin
                        step_ok  = 1'b1;
                        dir_up_d = 1'b1;
                    end else if (is_dn) begin
                        step_ok  = 1'b1;
                        dir_up_d = 1'b0;
                    end else begin
                        reject = 1'b1;
                        // An odd miss becomes the new reference so a glitch
                        // costs one error rather than a run of them.
                        if (d_odd) begin
                            last_d = bus.D;
                        end
                    end
                end
                FAULT: begin
                    reject = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (step_ok) begin
                last_d   = bus.D;
                lock_d   = 1'b1;
                consec_d = '0;
            end

            if (reject) begin
                error_d  = 1'b1;
                lock_d   = 1'b0;
                consec_d = consec_inc;
                if (consec_inc >= LIMIT) begin
                    state_d = FAULT;
                end
            end
        end

        fault_d = (state_d == FAULT);
    end

    // State and status registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            lock_q   <= 1'b0;
            dir_up_q <= 1'b1;
            error_q  <= 1'b0;
            fault_q  <= 1'b0;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            dir_up_q <= dir_up_d;
            error_q  <= error_d;
            fault_q  <= fault_d;
            consec_q <= consec_d;
        end
    end

    assign bus.Lock  = lock_q;
    assign bus.DirUp = dir_up_q;
    assign bus.Error = error_q;
    assign bus.Fault = fault_q;

`ifdef ODD_CHECK_STATS_EN
    logic [7:0]  err_count_q, err_count_d;
    logic [15:0] step_count_q, step_count_d;

    // Saturating reject count and wrapping legal-step count.
    always_comb begin
        err_count_d  = err_count_q;
        step_count_d = step_count_q;
        if (bus.Clear) begin
            err_count_d  = '0;
            step_count_d = '0;
        end else begin
            if (reject && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
            if (step_ok) begin
                step_count_d = step_count_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            err_count_q  <= '0;
            step_count_q <= '0;
        end else begin
            err_count_q  <= err_count_d;
            step_count_q <= step_count_d;
        end
    end

    assign bus.ErrCount  = err_count_q;
    assign bus.StepCount = step_count_q;
`else
    assign bus.ErrCount  = '0;
    assign bus.StepCount = '0;
`endif

endmodule
